// File: rtl/sram_mff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_mff_pkg
// Description : Shared constants, pointer/flag types and the flag helper for
//               the multi-channel SRAM FIFO pointer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_mff_pkg;

  // Default geometry: two channels sharing an 18-bit SRAM address space
  localparam int c_num_ch      = 2;
  localparam int c_ch_w        = 1;
  localparam int c_ch_addr_w   = 17;
  localparam int c_sram_addr_w = c_ch_w + c_ch_addr_w;
  localparam int c_cnt_w       = c_ch_addr_w + 1;
  localparam int c_ch_depth    = 1 << c_ch_addr_w;

  // Pointer layout: wrap bit above the in-region word address
  typedef struct packed {
    logic                   wrap;
    logic [c_ch_addr_w-1:0] addr;
  } mff_ptr_t;

  // Per-channel status flags
  typedef struct packed {
    logic empty;
    logic full;
    logic aempty;
    logic afull;
  } mff_flags_t;

  // Flags for a given occupancy; operands are zero-extended to 32 bits so
  // one function serves every channel-depth configuration.
  function automatic mff_flags_t mff_calc_flags(
    input logic [31:0] occ,
    input int unsigned ch_addr_w,
    input logic [31:0] aempty_th,
    input logic [31:0] afull_th
  );
    mff_flags_t f;
    f.empty  = (occ == 32'd0);
    f.full   = (occ == (32'd1 << ch_addr_w));
    f.aempty = (occ <= aempty_th);
    f.afull  = (occ >= afull_th);
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_mff_ch_ptr.sv
`default_nettype none
// ============================================================================
// Module      : sram_mff_ch_ptr
// Description : One FIFO channel: wrap-bit read/write pointers, flush,
//               occupancy and registered status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_mff_ch_ptr
  import sram_mff_pkg::*;
#(
  parameter int P_CH_ADDR_W = c_ch_addr_w,
  parameter int P_CNT_W     = c_cnt_w
) (
  input  logic                   clk_ir,
  input  logic                   rst_il,
  input  logic                   inc_wr_ih,
  input  logic                   inc_rd_ih,
  input  logic                   flush_ih,
  input  logic [P_CNT_W-1:0]     aempty_thresh_id,
  input  logic [P_CNT_W-1:0]     afull_thresh_id,
  output logic [P_CH_ADDR_W-1:0] wr_addr_od,
  output logic [P_CH_ADDR_W-1:0] rd_addr_od,
  output logic [P_CNT_W-1:0]     occ_od,
  output logic                   empty_oh,
  output logic                   full_oh,
  output logic                   aempty_oh,
  output logic                   afull_oh
);

  localparam logic [P_CNT_W-1:0] c_ptr_one = {{(P_CNT_W-1){1'b0}}, 1'b1};

  logic [P_CNT_W-1:0] r_wr_ptr;
  logic [P_CNT_W-1:0] r_rd_ptr;
  logic [P_CNT_W-1:0] r_occ;
  logic               r_empty;
  logic               r_full;
  logic               r_aempty;
  logic               r_afull;

  logic [P_CNT_W-1:0] w_wr_ptr_next;
  logic [P_CNT_W-1:0] w_rd_ptr_next;
  logic [P_CNT_W-1:0] w_occ_next;
  mff_flags_t         w_flags_next;

  // Next pointers; flush snaps the read pointer onto the post-write pointer,
  // so a write landing in the same cycle is discarded along with the rest.
  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    if (inc_wr_ih) begin
      w_wr_ptr_next = r_wr_ptr + c_ptr_one;
    end
    w_rd_ptr_next = r_rd_ptr;
    if (flush_ih) begin
      w_rd_ptr_next = w_wr_ptr_next;
    end else if (inc_rd_ih) begin
      w_rd_ptr_next = r_rd_ptr + c_ptr_one;
    end
    w_occ_next   = w_wr_ptr_next - w_rd_ptr_next;
    w_flags_next = mff_calc_flags(32'(w_occ_next), P_CH_ADDR_W,
                                  32'(aempty_thresh_id), 32'(afull_thresh_id));
  end

  // Register pointers, occupancy and flags from their next values
  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_occ    <= w_occ_next;
      r_empty  <= w_flags_next.empty;
      r_full   <= w_flags_next.full;
      r_aempty <= w_flags_next.aempty;
      r_afull  <= w_flags_next.afull;
    end
  end

  assign wr_addr_od = r_wr_ptr[P_CH_ADDR_W-1:0];
  assign rd_addr_od = r_rd_ptr[P_CH_ADDR_W-1:0];
  assign occ_od     = r_occ;
  assign empty_oh   = r_empty;
  assign full_oh    = r_full;
  assign aempty_oh  = r_aempty;
  assign afull_oh   = r_afull;

endmodule
`default_nettype wire

// File: rtl/sram_mff_cntrlr.sv
`default_nettype none
// ============================================================================
// Module      : sram_mff_cntrlr
// Description : Multi-channel SRAM FIFO pointer controller. Splits one SRAM
//               into P_NUM_CH circular regions, decodes read/write acks and
//               supplies full SRAM addresses. Optional sticky overflow /
//               underflow status is enabled with SRAM_MFF_ERR_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_mff_cntrlr
  import sram_mff_pkg::*;
#(
  parameter int P_NUM_CH      = c_num_ch,
  parameter int P_CH_W        = c_ch_w,
  parameter int P_CH_ADDR_W   = c_ch_addr_w,
  parameter int P_SRAM_ADDR_W = c_sram_addr_w,
  parameter int P_CNT_W       = c_cnt_w
) (
  input  logic                          clk_ir,
  input  logic                          rst_il,
  input  logic                          wr_en_ih,
  input  logic [P_CH_W-1:0]             wr_ch_id,
  input  logic                          rd_en_ih,
  input  logic [P_CH_W-1:0]             rd_ch_id,
  input  logic [P_NUM_CH-1:0]           flush_ih,
  input  logic [P_CNT_W-1:0]            aempty_thresh_id,
  input  logic [P_CNT_W-1:0]            afull_thresh_id,
  output logic                          wr_ack_oh,
  output logic                          rd_ack_oh,
  output logic [P_SRAM_ADDR_W-1:0]      sram_wr_addr_od,
  output logic [P_SRAM_ADDR_W-1:0]      sram_rd_addr_od,
  output logic [P_NUM_CH-1:0]           empty_oh,
  output logic [P_NUM_CH-1:0]           full_oh,
  output logic [P_NUM_CH-1:0]           aempty_oh,
  output logic [P_NUM_CH-1:0]           afull_oh,
`ifdef SRAM_MFF_ERR_STATS_EN
  input  logic                          err_clr_ih,
  output logic [P_NUM_CH-1:0]           ovf_oh,
  output logic [P_NUM_CH-1:0]           udf_oh,
`endif
  output logic [P_NUM_CH*P_CNT_W-1:0]   occ_od
);

  logic [P_NUM_CH-1:0]    w_inc_wr;
  logic [P_NUM_CH-1:0]    w_inc_rd;
  logic [P_CH_ADDR_W-1:0] w_wr_addr [P_NUM_CH];
  logic [P_CH_ADDR_W-1:0] w_rd_addr [P_NUM_CH];

  // A full channel refuses writes even if it is read in the same cycle;
  // reads are refused on empty or while that channel is being flushed.
  assign wr_ack_oh = wr_en_ih & ~full_oh[wr_ch_id];
  assign rd_ack_oh = rd_en_ih & ~empty_oh[rd_ch_id] & ~flush_ih[rd_ch_id];

  // Steer accepted requests to the addressed channel only
  always_comb begin
    w_inc_wr           = '0;
    w_inc_rd           = '0;
    w_inc_wr[wr_ch_id] = wr_ack_oh;
    w_inc_rd[rd_ch_id] = rd_ack_oh;
  end

  // Channel id forms the region base; pointer selects the word inside it
  assign sram_wr_addr_od = {wr_ch_id, w_wr_addr[wr_ch_id]};
  assign sram_rd_addr_od = {rd_ch_id, w_rd_addr[rd_ch_id]};

  generate
    for (genvar c = 0; c < P_NUM_CH; c++) begin : g_ch
      sram_mff_ch_ptr #(
        .P_CH_ADDR_W (P_CH_ADDR_W),
        .P_CNT_W     (P_CNT_W)
      ) u_ch_ptr (
        .clk_ir           (clk_ir),
        .rst_il           (rst_il),
        .inc_wr_ih        (w_inc_wr[c]),
        .inc_rd_ih        (w_inc_rd[c]),
        .flush_ih         (flush_ih[c]),
        .aempty_thresh_id (aempty_thresh_id),
        .afull_thresh_id  (afull_thresh_id),
        .wr_addr_od       (w_wr_addr[c]),
        .rd_addr_od       (w_rd_addr[c]),
        .occ_od           (occ_od[c*P_CNT_W +: P_CNT_W]),
        .empty_oh         (empty_oh[c]),
        .full_oh          (full_oh[c]),
        .aempty_oh        (aempty_oh[c]),
        .afull_oh         (afull_oh[c])
      );
    end
  endgenerate

`ifdef SRAM_MFF_ERR_STATS_EN
  logic [P_NUM_CH-1:0] w_ovf_set;
  logic [P_NUM_CH-1:0] w_udf_set;
  logic [P_NUM_CH-1:0] r_ovf;
  logic [P_NUM_CH-1:0] r_udf;

  // Error events: write to a full channel, read to an empty or flushing one
  always_comb begin
    w_ovf_set           = '0;
    w_udf_set           = '0;
    w_ovf_set[wr_ch_id] = wr_en_ih & full_oh[wr_ch_id];
    w_udf_set[rd_ch_id] = rd_en_ih & (empty_oh[rd_ch_id] | flush_ih[rd_ch_id]);
  end

  // Sticky error bits; a new event outranks a simultaneous clear
  always_ff @(posedge clk_ir) begin
    if (!rst_il) begin
      r_ovf <= '0;
      r_udf <= '0;
    end else begin
      r_ovf <= (err_clr_ih ? '0 : r_ovf) | w_ovf_set;
      r_udf <= (err_clr_ih ? '0 : r_udf) | w_udf_set;
    end
  end

  assign ovf_oh = r_ovf;
  assign udf_oh = r_udf;
`endif

endmodule
`default_nettype wire
